// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM memory port arbiter: FSM encoding, grant
// values and the tie-breaking rule.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    // Single eligible requester wins outright; a tie goes to whoever did not win last.
    function automatic logic pick_grant(input logic if_el, input logic dm_el, input logic last);
        if (if_el && dm_el) begin
            return ~last;
        end
        return dm_el ? GRANT_DM : GRANT_IF;
    endfunction

endpackage

// File: rtl/Mux2way32.sv
// 32-bit two-input multiplexer used to steer the shared memory port.
module Mux2way32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sel,
    output logic [31:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency 32-bit memory port between
// instruction fetch and data memory.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        grant_sel
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    arb_state_e    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          grant_next;
    logic          last_grant, last_next;
    logic          done, if_el, dm_el, winner;

    // Handshake: a requester raises req with stable payload and holds it until
    // its one-cycle ack; req still high on the cycle after ack is a new request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            cnt        <= '0;
            grant_sel  <= GRANT_IF;
            last_grant <= GRANT_IF;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            grant_sel  <= grant_next;
            last_grant <= last_next;
        end
    end

    // The finishing requester is excluded because its req is still high in its ack cycle.
    always_comb begin
        done       = (state == ARB_BUSY) && (cnt == '0);
        if_el      = if_req && !(done && grant_sel == GRANT_IF);
        dm_el      = dm_req && !(done && grant_sel == GRANT_DM);
        winner     = pick_grant(if_el, dm_el, last_grant);
        state_next = state;
        cnt_next   = cnt;
        grant_next = grant_sel;
        last_next  = last_grant;
        if (state == ARB_BUSY && !done) begin
            cnt_next = cnt - 1'b1;
        end else if (if_el || dm_el) begin
            state_next = ARB_BUSY;
            cnt_next   = CNT_LOAD;
            grant_next = winner;
            last_next  = winner;
        end else begin
            state_next = ARB_IDLE;
        end
    end

    always_comb begin
        mem_en = (state == ARB_BUSY);
        mem_we = (state == ARB_BUSY) && (grant_sel == GRANT_DM) && dm_we;
        if_ack = done && (grant_sel == GRANT_IF);
        dm_ack = done && (grant_sel == GRANT_DM);
    end

    Mux2way32 u_addr_mux (
        .a  (if_addr),
        .b  (dm_addr),
        .sel(grant_sel),
        .y  (mem_addr)
    );

    // IF never writes, so its write-data leg is tied off.
    Mux2way32 u_wdata_mux (
        .a  (32'd0),
        .b  (dm_wdata),
        .sel(grant_sel),
        .y  (mem_wdata)
    );

    assign if_rdata = mem_rdata;
    assign dm_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model
// of the IF/DM memory port arbiter.
module tb_mem_port_arbiter;

    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        if_ack, dm_ack, mem_en, mem_we, grant_sel;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    int vectors    = 0;
    int miscompares = 0;

    mem_port_arbiter #(.LATENCY(LATENCY)) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .grant_sel(grant_sel)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        if_req = 1'b0;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Flags are {mem_en, mem_we, if_ack, dm_ack, grant_sel}.
    task automatic test_reset();
        logic [4:0] got;
        reset    = 1'b1;
        if_req   = 1'b1;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        if_addr  = 32'h0040_0000;
        dm_addr  = 32'h1001_0000;
        dm_wdata = 32'h0;
        mem_rdata = 32'h0;
        for (int c = 0; c < 3; c++) begin
            tick();
            got = {mem_en, mem_we, if_ack, dm_ack, grant_sel};
            vectors++;
            if (got !== 5'b00000) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d flags got=%b exp=00000", c, got);
            end
        end
        reset = 1'b0;
        tick();
        got = {mem_en, mem_we, if_ack, dm_ack, grant_sel};
        vectors++;
        if (got !== 5'b10001) begin
            miscompares++;
            $display("FAIL reset_first_tie cyc=1 flags got=%b exp=10001", got);
        end
        tick();
        got = {mem_en, mem_we, if_ack, dm_ack, grant_sel};
        vectors++;
        if (got !== 5'b10011) begin
            miscompares++;
            $display("FAIL reset_first_tie cyc=2 flags got=%b exp=10011", got);
        end
    endtask

    task automatic test_if_read();
        logic [4:0] got;
        logic [4:0] exp_f [1:3];
        exp_f[1] = 5'b10000;
        exp_f[2] = 5'b10100;
        exp_f[3] = 5'b00000;
        do_reset();
        if_req    = 1'b1;
        if_addr   = 32'h0040_0000;
        mem_rdata = 32'h8C08_0004;
        for (int c = 1; c <= 3; c++) begin
            tick();
            got = {mem_en, mem_we, if_ack, dm_ack, grant_sel};
            vectors++;
            if (got !== exp_f[c]) begin
                miscompares++;
                $display("FAIL if_read cyc=%0d flags got=%b exp=%b", c, got, exp_f[c]);
            end
            if (c < 3) begin
                vectors++;
                if (mem_addr !== 32'h0040_0000) begin
                    miscompares++;
                    $display("FAIL if_read_addr cyc=%0d got=%h exp=00400000", c, mem_addr);
                end
            end
            if (c == 2) begin
                vectors++;
                if (if_rdata !== 32'h8C08_0004) begin
                    miscompares++;
                    $display("FAIL if_read_rdata got=%h exp=8c080004", if_rdata);
                end
                if_req = 1'b0;
            end
        end
    endtask

    task automatic test_dm_write();
        logic [4:0] got;
        logic [4:0] exp_f [1:3];
        exp_f[1] = 5'b11001;
        exp_f[2] = 5'b11011;
        exp_f[3] = 5'b00001;
        do_reset();
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h1001_0000;
        dm_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 3; c++) begin
            tick();
            got = {mem_en, mem_we, if_ack, dm_ack, grant_sel};
            vectors++;
            if (got !== exp_f[c]) begin
                miscompares++;
                $display("FAIL dm_write cyc=%0d flags got=%b exp=%b", c, got, exp_f[c]);
            end
            if (c < 3) begin
                vectors++;
                if (mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h1001_0000) begin
                    miscompares++;
                    $display("FAIL dm_write_data cyc=%0d got addr=%h wdata=%h exp addr=10010000 wdata=deadbeef",
                             c, mem_addr, mem_wdata);
                end
            end
            if (c == 2) begin
                dm_req = 1'b0;
                dm_we  = 1'b0;
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] got;
        logic [4:0] exp_f [1:5];
        exp_f[1] = 5'b10001;
        exp_f[2] = 5'b10011;
        exp_f[3] = 5'b10000;
        exp_f[4] = 5'b10100;
        exp_f[5] = 5'b00000;
        do_reset();
        if_req = 1'b1;
        dm_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            got = {mem_en, mem_we, if_ack, dm_ack, grant_sel};
            vectors++;
            if (got !== exp_f[c]) begin
                miscompares++;
                $display("FAIL simultaneous cyc=%0d flags got=%b exp=%b", c, got, exp_f[c]);
            end
            if (c == 2) dm_req = 1'b0;
            if (c == 4) if_req = 1'b0;
        end
    endtask

    task automatic test_contention();
        logic [3:0] got, exp_f;
        int n_acks;
        do_reset();
        if_req = 1'b1;
        dm_req = 1'b1;
        n_acks = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            exp_f[3] = 1'b1;
            exp_f[2] = (c % 2 == 0) && ((c / 2) % 2 == 0);
            exp_f[1] = (c % 2 == 0) && ((c / 2) % 2 == 1);
            exp_f[0] = (((c - 1) / 2) % 2 == 0);
            got = {mem_en, if_ack, dm_ack, grant_sel};
            if (if_ack === 1'b1 || dm_ack === 1'b1) n_acks++;
            vectors++;
            if (got !== exp_f) begin
                miscompares++;
                $display("FAIL contention cyc=%0d {en,if_ack,dm_ack,sel} got=%b exp=%b", c, got, exp_f);
            end
        end
        vectors++;
        if (n_acks != 8) begin
            miscompares++;
            $display("FAIL contention_ack_count got=%0d exp=8", n_acks);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] got;
        do_reset();
        if_req  = 1'b1;
        if_addr = 32'h0040_0010;
        tick();
        vectors++;
        if (mem_en !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_start mem_en got=%b exp=1", mem_en);
        end
        reset  = 1'b1;
        if_req = 1'b0;
        tick();
        reset = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            got = {mem_en, mem_we, if_ack, dm_ack, grant_sel};
            vectors++;
            if (got !== 5'b00000) begin
                miscompares++;
                $display("FAIL reset_mid cyc=%0d flags got=%b exp=00000", c, got);
            end
            tick();
        end
    endtask

    // Transaction-level reference: who owns the port and how many cycles it has left.
    task automatic test_random();
        bit   m_active, m_who, m_last, done, ie, de, w;
        int   m_left;
        bit   if_acked_prev, dm_acked_prev;
        logic exp_if_ack, exp_dm_ack, exp_en, exp_we;
        logic [31:0] exp_addr, exp_wdata;
        do_reset();
        m_active = 1'b0; m_who = 1'b0; m_last = 1'b0; m_left = 0;
        if_acked_prev = 1'b0; dm_acked_prev = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!if_req || if_acked_prev) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom;
            end
            if (!dm_req || dm_acked_prev) begin
                dm_req   = ($urandom_range(0, 2) != 0);
                dm_we    = $urandom_range(0, 1);
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
            mem_rdata = $urandom;
            #1;
            exp_en     = m_active;
            exp_we     = m_active && m_who && dm_we;
            exp_if_ack = m_active && (m_left == 1) && !m_who;
            exp_dm_ack = m_active && (m_left == 1) && m_who;
            exp_addr   = m_who ? dm_addr : if_addr;
            exp_wdata  = m_who ? dm_wdata : 32'd0;
            vectors++;
            if ({mem_en, mem_we, if_ack, dm_ack, grant_sel} !==
                {exp_en, exp_we, exp_if_ack, exp_dm_ack, m_who}) begin
                miscompares++;
                $display("FAIL random_flags cyc=%0d got=%b exp=%b", cyc,
                         {mem_en, mem_we, if_ack, dm_ack, grant_sel},
                         {exp_en, exp_we, exp_if_ack, exp_dm_ack, m_who});
            end
            vectors++;
            if (mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin
                miscompares++;
                $display("FAIL random_mux cyc=%0d got addr=%h wdata=%h exp addr=%h wdata=%h",
                         cyc, mem_addr, mem_wdata, exp_addr, exp_wdata);
            end
            if (exp_if_ack || exp_dm_ack) begin
                vectors++;
                if ((exp_if_ack ? if_rdata : dm_rdata) !== mem_rdata) begin
                    miscompares++;
                    $display("FAIL random_rdata cyc=%0d got=%h exp=%h", cyc,
                             exp_if_ack ? if_rdata : dm_rdata, mem_rdata);
                end
            end
            if_acked_prev = exp_if_ack;
            dm_acked_prev = exp_dm_ack;
            done = m_active && (m_left == 1);
            if (m_active && !done) begin
                m_left--;
            end else begin
                ie = if_req && !(done && !m_who);
                de = dm_req && !(done && m_who);
                if (ie || de) begin
                    w        = (ie && de) ? !m_last : de;
                    m_active = 1'b1;
                    m_who    = w;
                    m_last   = w;
                    m_left   = LATENCY;
                end else begin
                    m_active = 1'b0;
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_dm_write();
        test_simultaneous();
        test_contention();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single 32-bit memory port between instruction fetch (IF) and data memory (DM) in the MIPS datapath. It sequences each access through a fixed-latency memory, steers address and write data through Mux2way32 instances via its grant select, and returns a one-cycle acknowledge to the winning requester. Ties are resolved round-robin, with DM winning the first tie after reset.

## Interface
- LATENCY, 2, memory access cycles per transaction; legal range ≥1
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- if_req  input  1  IF request; held high until if_ack
- if_addr  input  32  IF word address; stable while if_req is high
- if_ack  output  1  one-cycle pulse; if_rdata is valid in this cycle
- if_rdata  output  32  read data to IF (equals mem_rdata)
- dm_req  input  1  DM request; held high until dm_ack
- dm_we  input  1  DM write enable; stable while dm_req is high
- dm_addr  input  32  DM address; stable while dm_req is high
- dm_wdata  input  32  DM write data; stable while dm_req is high
- dm_ack  output  1  one-cycle pulse completing a DM access
- dm_rdata  output  32  read data to DM (equals mem_rdata)
- mem_en  output  1  memory port active
- mem_we  output  1  memory write strobe
- mem_addr  output  32  memory address (muxed)
- mem_wdata  output  32  memory write data (muxed)
- mem_rdata  input  32  memory read data; valid in the last cycle of a transaction
- grant_sel  output  1  0 = IF, 1 = DM; drives the Mux2way32 selects

## Operation
- State: IDLE or BUSY, plus a down-counter cnt, a grant_sel register and a last_grant register.
- Arbitration on eligible requests:
  - Only one eligible: grant it.
  - Both eligible: grant the opposite of last_grant.
- IDLE, with any request: register the grant into grant_sel and last_grant, set cnt = LATENCY-1, go to BUSY.
- BUSY, cnt > 0: decrement cnt.
- BUSY, cnt == 0 (completion cycle):
  - Assert the granted requester's ack.
  - Arbitrate with the granted requester excluded, because its req is still high this cycle.
  - If the other requester is requesting, re-grant and stay in BUSY with cnt = LATENCY-1, with no idle gap.
  - Otherwise go to IDLE.
- A requester that keeps req high on the cycle after its ack is issuing a new request.
- Datapath outputs:
  - mem_addr = grant_sel ? dm_addr : if_addr
  - mem_wdata = grant_sel ? dm_wdata : if_wdata-less path (IF never writes; mux input a is tied to 0)
  - mem_en = (state == BUSY)
  - mem_we = BUSY & grant_sel & dm_we
- if_rdata and dm_rdata are continuous copies of mem_rdata. They are meaningful only with the matching ack.
- Reset values:
  - state = IDLE, cnt = 0, grant_sel = 0, last_grant = 0 (IF, so the first tie goes to DM).
  - if_ack = dm_ack = mem_en = mem_we = 0.
- Reset mid-transaction aborts the access. No ack is issued, and the port is IDLE on the following cycle.
- A request that drops before its ack is a protocol violation. Behaviour is unspecified and need not be handled.

## Timing
- Request seen in IDLE at cycle 0 → BUSY during cycles 1..LATENCY → ack in cycle LATENCY.
- With LATENCY = 1, the ack falls in cycle 1.
- Back-to-back: the second grant's BUSY window starts the cycle after the first ack.
  - Sustained throughput is one access per LATENCY cycles.
- All acks come from state only; no combinational path from req to ack.
- The mux outputs are combinational from grant_sel and the requester inputs.

## Structure
- Package mem_arb_pkg holds:
  - the state encoding (ARB_IDLE, ARB_BUSY)
  - the grant constants GRANT_IF = 1'b0, GRANT_DM = 1'b1
- Sub-module: two Mux2way32 instances, one for mem_addr and one for mem_wdata, both selected by grant_sel.
- FSM, counter and round-robin logic live in the top-level block.

## Test plan
- **Reset:** hold reset 3 cycles with both reqs high → all outputs 0, grant_sel = 0; first tie after release is granted to DM.
- **Single IF read, LATENCY = 2:** if_req with if_addr = 0x00400000, mem_rdata = 0x8C080004 → mem_en high in cycles 1–2, mem_addr = 0x00400000, if_ack only in cycle 2 with if_rdata = 0x8C080004, mem_we = 0 throughout.
- **DM write:** dm_req, dm_we = 1, dm_addr = 0x10010000, dm_wdata = 0xDEADBEEF → mem_we and mem_en high in cycles 1–2, mem_wdata = 0xDEADBEEF, dm_ack in cycle 2.
- **Simultaneous requests after reset:** both reqs at cycle 0 → DM served in cycles 1–2 (dm_ack at 2), IF granted without a gap in cycles 3–4 (if_ack at 4, grant_sel = 0 in cycle 3).
- **Sustained contention:** both reqs held high for 8 accesses → grants alternate DM, IF, DM, IF…; one ack every 2 cycles; never two acks in the same cycle.
- **Reset mid-access:** reset asserted in cycle 1 of an IF access → no if_ack, and mem_en = 0 from the cycle after reset onward.
